// File: rtl/png_crc_pkg.sv
// rtl/png_crc_pkg.sv - constants, state encoding and bit-reverse helpers for the PNG CRC-32 path
package png_crc_pkg;

  localparam logic [31:0] CRC_POLY_NRM = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT   = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACTV     = 2'd1;
  localparam logic [1:0] ST_PROC     = 2'd2;
  localparam logic [1:0] ST_WAIT_CRC = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    ACTV     = ST_ACTV,
    PROC     = ST_PROC,
    WAIT_CRC = ST_WAIT_CRC
  } crc_state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - combinational 8-step MSB-first CRC-32 LFSR over one normal-order byte
module crc32_byte_step
  import png_crc_pkg::*;
(
  input  logic [31:0] crc_cur_i,
  input  logic [7:0]  byte_nrm_i,
  output logic [31:0] crc_nxt_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_cur_i ^ {byte_nrm_i, 24'h0};
    for (int i = 0; i < 8; i++) begin
      c = c[31] ? ((c << 1) ^ CRC_POLY_NRM) : (c << 1);
    end
    crc_nxt_o = c;
  end

endmodule

// File: rtl/png_crc_chk.sv
// rtl/png_crc_chk.sv - PNG chunk CRC-32 checker, one byte folded per cycle, stored CRC word last
module png_crc_chk
  import png_crc_pkg::*;
#(
  parameter int          DATA_WD    = 32,
  parameter logic [31:0] CRC_INIT   = png_crc_pkg::CRC_INIT,
  parameter logic [31:0] CRC_XOROUT = png_crc_pkg::CRC_XOROUT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  input  logic [1:0]         lst_bytes_i,
  output logic               done_o,
  output logic               ok_o,
  output logic               err_o,
  output logic [31:0]        crc_o
);

  crc_state_e         state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [DATA_WD-1:0] buf_q, buf_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         end_q, end_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [31:0]        crco_q, crco_d;

  logic        hs;
  logic [7:0]  byte_sel;
  logic [31:0] crc_step;
  logic [31:0] crc_fin;

  assign rdy_o   = (state_q == ACTV) || (state_q == WAIT_CRC);
  assign hs      = val_i & rdy_o;
  assign crc_fin = bitrev32(crc_q) ^ CRC_XOROUT;

  // ACTV folds the leading byte straight off the bus; PROC walks the buffer
  always_comb begin
    byte_sel = buf_q[31:24];
    if (state_q == ACTV) begin
      byte_sel = dat_i[31:24];
    end else begin
      case (idx_q)
        2'd1:    byte_sel = buf_q[23:16];
        2'd2:    byte_sel = buf_q[15:8];
        2'd3:    byte_sel = buf_q[7:0];
        default: byte_sel = buf_q[31:24];
      endcase
    end
  end

  crc32_byte_step u_step (
    .crc_cur_i (crc_q),
    .byte_nrm_i(bitrev8(byte_sel)),
    .crc_nxt_o (crc_step)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    end_d   = end_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    crco_d  = crco_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          crc_d   = CRC_INIT;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          crco_d  = 32'h0;
          state_d = ACTV;
        end
      end
      ACTV: begin
        if (hs) begin
          buf_d  = dat_i;
          crc_d  = crc_step;
          idx_d  = 2'd1;
          last_d = lst_i;
          // index of the final valid byte; a count of 0 means 4 and wraps to 3
          end_d  = lst_i ? (lst_bytes_i - 2'd1) : 2'd3;
          state_d = (lst_i && (lst_bytes_i == 2'd1)) ? WAIT_CRC : PROC;
        end
      end
      PROC: begin
        crc_d = crc_step;
        idx_d = idx_q + 2'd1;
        if (idx_q == end_q) begin
          state_d = last_q ? WAIT_CRC : ACTV;
        end
      end
      WAIT_CRC: begin
        if (hs) begin
          done_d  = 1'b1;
          ok_d    = (dat_i == crc_fin);
          err_d   = (dat_i != crc_fin);
          crco_d  = crc_fin;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      crc_q   <= 32'h0;
      buf_q   <= '0;
      idx_q   <= 2'd0;
      end_q   <= 2'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      crco_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      crco_q  <= crco_d;
    end
  end

  assign done_o = done_q;
  assign ok_o   = ok_q;
  assign err_o  = err_q;
  assign crc_o  = crco_q;

endmodule

// File: doc/png_crc_chk.md
Name: png_crc_chk

Overview:
- Decoder-side CRC-32 checker for the PNG chunk path.
- Consumes the CRC-covered bytes of a chunk (type + data) as 32-bit words, MSB-first, then one trailing word carrying the stored CRC.
- Computes the PNG CRC-32: reflected poly 0x04C11DB7 / 0xEDB88320, init 0xFFFFFFFF, xorout 0xFFFFFFFF. Compares it with the stored CRC and reports pass/fail.
- Sits between the chunk parser and the inflate front-end; one byte processed per cycle.

Parameters:
- DATA_WD, 32: input word width. Only 32 is supported.
- CRC_INIT, 32'hFFFF_FFFF: CRC register load value on start.
- CRC_XOROUT, 32'hFFFF_FFFF: final XOR applied before compare and output.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  begin new chunk check; honoured only in IDLE
- val_i  in  1  input word valid
- rdy_o  out  1  checker can accept a word this cycle
- dat_i  in  32  input word; first byte in [31:24]
- lst_i  in  1  current word is the last CRC-covered word
- lst_bytes_i  in  2  valid bytes in last word (0 = 4, 1..3 = that many, left-aligned from [31:24]); sampled only with lst_i
- done_o  out  1  one-cycle pulse: check complete
- ok_o  out  1  computed CRC == stored CRC; held until next start
- err_o  out  1  mismatch; held until next start
- crc_o  out  32  computed final CRC (after xorout); valid from done_o, held until next start

Behaviour:
- Handshake: a word transfers on val_i & rdy_o. rdy_o is high only in ACTV and WAIT_CRC. val_i is ignored in all other states.
- FSM states: IDLE, ACTV, PROC, WAIT_CRC.
  - IDLE: start_i -> crc_r <= CRC_INIT; clear ok_o, err_o, crc_o; go to ACTV. start_i in any other state is ignored.
  - ACTV: on handshake, latch the word into the buffer and fold byte [31:24] into crc_r in the same cycle.
    - Non-last word, or last word with 2..4 valid bytes: go to PROC.
    - Last word with 1 valid byte: go to WAIT_CRC.
    - No handshake: stay in ACTV.
  - PROC: fold one buffered byte per cycle in order [23:16], [15:8], [7:0]; a 2-bit byte index counts them.
    - Stop after the number of valid bytes: 4 for non-last words, lst_bytes_i for the last word (latched at handshake).
    - Then go to ACTV if the word was not last, else WAIT_CRC.
  - WAIT_CRC: on handshake, dat_i is the stored CRC, big-endian as in the PNG file.
    - Compare with crc_fin = bitrev(crc_r) ^ CRC_XOROUT.
    - At that edge: done_o <= 1, ok_o <= equal, err_o <= !equal, crc_o <= crc_fin. Go to IDLE.
    - lst_i is don't-care on this word.
- Byte fold:
  - Input byte is bit-reversed into normal order.
  - crc_r is kept in normal (non-reflected) order and bit-reversed at output.
  - Next value is 8-step LFSR of poly 0x04C11DB7, all combinational.
- Throughput and latency:
  - Full word: 4 cycles, i.e. rdy_o high once per 4 cycles under continuous val_i.
  - Last word: lst_bytes cycles (4 if 0).
  - done_o: exactly 1 cycle after the CRC-word handshake.
- Reset values: all outputs 0. State IDLE, crc_r 0, buffer 0.
- rstn asserted mid-chunk aborts immediately. done_o is never produced for the aborted chunk.
- done_o is a single-cycle pulse. ok_o and err_o are mutually exclusive and both 0 between start and done.

Decomposition:
- Package png_crc_pkg:
  - Constants: CRC_POLY_NRM = 32'h04C1_1DB7, CRC_INIT, CRC_XOROUT.
  - State encoding localparams: 2-bit IDLE / ACTV / PROC / WAIT_CRC.
  - bitrev8 / bitrev32 functions.
- Sub-module crc32_byte_step: purely combinational, (crc_cur[31:0], byte_nrm[7:0]) -> crc_nxt[31:0]. Shared with the encoder-side generator for future reuse.

Test Plan:
- "IEND" (word 0x49454E44, lst_i=1, lst_bytes_i=0), then CRC word 0xAE426082 -> done_o pulse 1 cycle after CRC handshake; ok_o=1, err_o=0, crc_o=0xAE426082. Data and CRC handshakes are 4 cycles apart.
- "123456789" as 0x31323334, 0x35363738, 0x39xxxxxx (lst_bytes_i=1), then CRC word 0xCBF43926 -> ok_o=1, crc_o=0xCBF43926. The last data word takes 1 cycle; rdy_o is high the next cycle in WAIT_CRC.
- Same as the IEND case but CRC word 0xAE426083 -> err_o=1, ok_o=0, crc_o=0xAE426082.
- Back-to-back: two IEND checks with start_i the cycle after done_o; val_i held high continuously -> second result correct. rdy_o is never high in PROC/IDLE; ok_o and err_o are cleared at the second start.
- Abort: rstn pulsed low during PROC of a 3-word chunk -> all outputs 0 immediately, no done_o. A following IEND check passes.
- Ignored inputs: start_i toggled during ACTV/PROC and val_i asserted in IDLE/PROC -> no state or CRC change; the IEND check still yields ok_o=1.
